// File: rtl/elevador_pkg.sv
// elevador_pkg: shared FSM states and seven-segment lookup for the elevator controller
package elevador_pkg;
  typedef enum logic [1:0] {REPOSO, SUBIENDO, BAJANDO, PUERTA} estado_t;
  localparam logic [6:0] SEG7_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  function automatic logic [6:0] seg7(input logic [3:0] v);
    return SEG7_TAB[v];
  endfunction
endpackage

// File: rtl/elevador_ctrl_seg7_dec.sv
// seg7_dec: registered hex to seven-segment decoder (gfedcba, active high)
module seg7_dec
  import elevador_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] val,
  output logic [6:0] seg
);
  always_ff @(posedge clk or posedge rst)
    if (rst) seg <= 7'h3F;
    else     seg <= seg7(val);
endmodule

// File: rtl/elevador_ctrl.sv
// elevador_ctrl: collective (SCAN) elevator scheduler with call latch, travel/dwell timing
// and a registered floor display.
module elevador_ctrl
  import elevador_pkg::*;
#(
  parameter int FLOORS      = 4,
  parameter int FLOOR_TICKS = 1000,
  parameter int DOOR_TICKS  = 500,
  localparam int FW         = $clog2(FLOORS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] boton,
  input  logic              paro,
  output logic              motor_subir,
  output logic              motor_bajar,
  output logic              puerta,
  output logic [FW-1:0]     piso,
  output logic [FLOORS-1:0] pedidos,
  output logic [6:0]        display
);
  estado_t est, est_n;
  logic [FW-1:0] piso_n, nf;
  logic [FLOORS-1:0] ped_n, pend, ones, clr, blk;
  logic [FLOORS-1:0] arriba, abajo, arriba_n, abajo_n;
  logic [31:0] cnt, cnt_n;
  logic dir, dir_n, decide, aqui, ade, atr, tick_f, tick_d;
  always_comb begin
    ones     = '1;
    pend     = pedidos | boton;
    aqui     = boton[piso] | pedidos[piso];
    // idle/door decisions use only latched calls, giving one edge of call-to-motor latency
    arriba   = pedidos & (ones << (int'(piso) + 1));
    abajo    = pedidos & ~(ones << piso);
    ade      = dir ? |arriba : |abajo;
    atr      = dir ? |abajo : |arriba;
    nf       = (est == SUBIENDO) ? ((piso == FW'(FLOORS-1)) ? piso : piso + FW'(1))
                                 : ((piso == '0) ? piso : piso - FW'(1));
    arriba_n = pend & (ones << (int'(nf) + 1));
    abajo_n  = pend & ~(ones << nf);
    tick_f   = cnt == 32'(FLOOR_TICKS - 1);
    tick_d   = cnt == 32'(DOOR_TICKS - 1);
    est_n    = est;
    piso_n   = piso;
    cnt_n    = cnt;
    dir_n    = dir;
    clr      = '0;
    blk      = '0;
    decide   = 1'b0;
    if (est == REPOSO || est == PUERTA) blk[piso] = 1'b1;
    if (!paro)
      case (est)
        REPOSO: decide = 1'b1;
        PUERTA:
          if (boton[piso]) cnt_n = '0;
          else if (tick_d) decide = 1'b1;
          else cnt_n = cnt + 1;
        default:
          if (!tick_f) cnt_n = cnt + 1;
          else begin
            cnt_n  = '0;
            piso_n = nf;
            if (pend[nf]) begin
              clr[nf] = 1'b1;
              est_n   = PUERTA;
            end else if (!((est == SUBIENDO) ? |arriba_n : |abajo_n)) est_n = REPOSO;
          end
      endcase
    if (decide) begin
      cnt_n = '0;
      est_n = aqui ? PUERTA : ade ? (dir ? SUBIENDO : BAJANDO)
            : atr ? (dir ? BAJANDO : SUBIENDO) : REPOSO;
      dir_n = (!aqui && !ade && atr) ? !dir : dir;
    end
    ped_n = (pedidos | (boton & ~blk)) & ~clr;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      est         <= REPOSO;
      piso        <= '0;
      pedidos     <= '0;
      cnt         <= '0;
      dir         <= 1'b1;
      motor_subir <= 1'b0;
      motor_bajar <= 1'b0;
      puerta      <= 1'b0;
    end else begin
      est         <= est_n;
      piso        <= piso_n;
      pedidos     <= ped_n;
      cnt         <= cnt_n;
      dir         <= dir_n;
      motor_subir <= est_n == SUBIENDO && !paro;
      motor_bajar <= est_n == BAJANDO && !paro;
      puerta      <= est_n == PUERTA;
    end
  seg7_dec u_seg (
    .clk(clk),
    .rst(rst),
    .val(4'(piso_n)),
    .seg(display)
  );
endmodule

// File: tb/tb_elevador_ctrl.sv
// tb_elevador_ctrl: directed scenarios with hand-computed expectations (4 floors, 4/3 ticks)
module tb_elevador_ctrl;
  logic clk = 1'b0, rst = 1'b1, paro = 1'b0;
  logic [3:0] boton = '0, pedidos;
  logic motor_subir, motor_bajar, puerta;
  logic [1:0] piso;
  logic [6:0] display;
  int total = 0, bad = 0, n_sub = 0, n_baj = 0, n_door = 0, n_both = 0;
  elevador_ctrl #(.FLOORS(4), .FLOOR_TICKS(4), .DOOR_TICKS(3)) dut (
    .clk(clk), .rst(rst), .boton(boton), .paro(paro),
    .motor_subir(motor_subir), .motor_bajar(motor_bajar), .puerta(puerta),
    .piso(piso), .pedidos(pedidos), .display(display)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      if (motor_subir) n_sub++;
      if (motor_bajar) n_baj++;
      if (puerta) n_door++;
      if (motor_subir && motor_bajar) n_both++;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    n_sub = 0; n_baj = 0; n_door = 0;
  endtask
  task automatic press(input logic [3:0] b);
    boton = b;
    step(1);
    boton = '0;
  endtask
  initial begin
    // reset and idle
    do_reset();
    step(20);
    chk("idle_piso", piso, 0);
    chk("idle_disp", display, 7'h3F);
    chk("idle_outs", {motor_subir, motor_bajar, puerta}, 0);
    chk("idle_ped", pedidos, 0);
    press(4'b0001);
    chk("here_door", puerta, 1);
    chk("here_noped", pedidos, 0);
    step(5);
    chk("here_close", puerta, 0);
    // single call to top floor
    do_reset();
    press(4'b1000);
    chk("c3_latch", pedidos, 4'b1000);
    chk("c3_nomotor", motor_subir, 0);
    step(1);
    chk("c3_motor", motor_subir, 1);
    step(4);
    chk("c3_p1", piso, 1);
    chk("c3_d1", display, 7'h06);
    step(4);
    chk("c3_p2", piso, 2);
    chk("c3_d2", display, 7'h5B);
    step(4);
    chk("c3_arr", {piso, motor_subir, puerta}, {2'd3, 1'b0, 1'b1});
    chk("c3_ped0", pedidos, 0);
    chk("c3_d3", display, 7'h4F);
    step(3);
    chk("c3_close", puerta, 0);
    step(10);
    chk("c3_nsub", n_sub, 12);
    chk("c3_ndoor", n_door, 3);
    chk("c3_nbaj", n_baj, 0);
    // two calls served in one upward sweep
    do_reset();
    press(4'b1010);
    step(5);
    chk("c13_p1", {piso, puerta, motor_subir}, {2'd1, 1'b1, 1'b0});
    chk("c13_ped", pedidos, 4'b1000);
    step(3);
    chk("c13_go", {puerta, motor_subir}, 2'b01);
    step(8);
    chk("c13_p3", {piso, puerta}, {2'd3, 1'b1});
    chk("c13_ped0", pedidos, 0);
    step(10);
    chk("c13_nsub", n_sub, 12);
    chk("c13_nbaj", n_baj, 0);
    chk("c13_ndoor", n_door, 6);
    // direction reversal from floor 2
    do_reset();
    press(4'b0100);
    step(15);
    chk("rev_at2", {piso, puerta, motor_subir}, {2'd2, 1'b0, 1'b0});
    n_sub = 0; n_baj = 0; n_door = 0;
    press(4'b0001);
    chk("rev_latch", pedidos, 4'b0001);
    step(1);
    chk("rev_down", motor_bajar, 1);
    step(8);
    chk("rev_arr", {piso, puerta, motor_bajar}, {2'd0, 1'b1, 1'b0});
    chk("rev_ped0", pedidos, 0);
    step(10);
    chk("rev_nbaj", n_baj, 8);
    chk("rev_nsub", n_sub, 0);
    chk("rev_ndoor", n_door, 3);
    // emergency stop mid-travel with a call during the stop
    do_reset();
    press(4'b1000);
    step(3);
    chk("paro_pre", motor_subir, 1);
    paro = 1'b1;
    boton = 4'b0010;
    step(1);
    boton = '0;
    chk("paro_latch", pedidos, 4'b1010);
    for (int i = 0; i < 4; i++) begin
      chk("paro_motor", {motor_subir, motor_bajar, puerta}, 0);
      step(1);
    end
    chk("paro_piso", piso, 0);
    paro = 1'b0;
    step(1);
    chk("paro_resume", motor_subir, 1);
    step(1);
    chk("paro_p1", {piso, puerta}, {2'd1, 1'b1});
    step(20);
    chk("paro_nsub", n_sub, 12);
    chk("paro_ndoor", n_door, 6);
    chk("paro_end", {piso, pedidos}, {2'd3, 4'b0});
    // asynchronous reset between floors 1 and 2
    do_reset();
    press(4'b1000);
    step(7);
    chk("rst_pre", {piso, motor_subir}, {2'd1, 1'b1});
    rst = 1'b1;
    #1;
    chk("rst_async", {piso, pedidos, motor_subir, motor_bajar, puerta}, 0);
    chk("rst_disp", display, 7'h3F);
    step(1);
    rst = 1'b0;
    step(10);
    chk("rst_stay", {piso, pedidos, motor_subir, motor_bajar, puerta}, 0);
    chk("both_never", n_both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/elevador_ctrl.md
# elevador_ctrl

Parametrised elevator controller for an N-floor car: latches hall/cab call buttons, schedules service with a collective (SCAN) policy, drives up/down motor enables, times floor-to-floor travel and door dwell, and shows the current floor on a seven-segment display. It replaces the fixed two-button stub as the core of the elevator top level. The tile wrapper instantiates it and maps its ports to the dedicated and bidirectional pins.

## Interface
- `FLOORS`, 4, number of floors; legal range 2..16.
- `FLOOR_TICKS`, 1000, clock cycles of motor drive per floor traversed; must be ≥1.
- `DOOR_TICKS`, 500, clock cycles the door stays open per stop; must be ≥1.
- `FW`, derived, `$clog2(FLOORS)`; not overridable.

Ports:
- `clk`  in  1  single clock; all state is on its rising edge.
- `rst`  in  1  **asynchronous, active-high reset**.
- `boton`  in  FLOORS  call buttons; bit i high = request floor i; level-sampled every cycle.
- `paro`  in  1  emergency stop, active high.
- `motor_subir`  out  1  motor up enable.
- `motor_bajar`  out  1  motor down enable; never high together with `motor_subir`.
- `puerta`  out  1  door open.
- `piso`  out  FW  current floor index.
- `pedidos`  out  FLOORS  pending request bitmap.
- `display`  out  7  seven-segment code of `piso`, active-high, bit order gfedcba, hex digits 0–F.

## Operation
- States: `REPOSO` (idle, door closed), `SUBIENDO`, `BAJANDO`, `PUERTA`. Direction memory `dir_arriba` starts at 1.
- Request latch: `pedidos[i]` is set at the edge where `boton[i]=1`. It stays set until serviced. A press for floor `piso` while in `PUERTA` or `REPOSO` is not latched. In `REPOSO` it opens the door instead; in `PUERTA` it restarts the dwell timer.
- `REPOSO`:
  - Request at the current floor → `PUERTA`.
  - Otherwise, if requests exist in the `dir_arriba` direction → move that way.
  - Otherwise, if requests exist in the opposite direction → flip `dir_arriba` and move.
  - Otherwise stay in `REPOSO`.
- `SUBIENDO`/`BAJANDO`:
  - A travel counter runs from 0 to FLOOR_TICKS-1.
  - On wrap, `piso` moves ±1.
  - If the new floor has a request, clear it and go to `PUERTA`.
  - Otherwise continue while requests remain ahead. If none remain ahead, go to `REPOSO` at the new floor.
- `PUERTA`:
  - The dwell counter runs for DOOR_TICKS cycles.
  - On expiry, apply the `REPOSO` decision in the same edge (direct to `SUBIENDO`/`BAJANDO`/`REPOSO`).
- `paro`: while high, the travel and dwell counters freeze, both motor outputs are forced low, `puerta` holds its value, and requests are still latched. On release, operation resumes from the frozen count.
- `piso` saturates: never below 0 or above FLOORS-1. A request above FLOORS-1 cannot exist because `boton` is FLOORS wide.

## Timing
- Reset values: state `REPOSO`, `piso`=0, `pedidos`=0, all motors/`puerta`=0, `display`=segment code for 0 (7'h3F), counters 0, `dir_arriba`=1.
- All outputs are registered.
- `display` follows `piso` with zero added latency: it is decoded from the `piso` register into a registered output updated on the same edge.
- Call to motor: `boton` high at edge k → `pedidos` bit at k → state/motor change at edge k+1.
- Motor stays high exactly FLOOR_TICKS cycles per floor, excluding `paro` cycles.
- On arrival at a requested floor, `piso` updates, the request clears, the motor drops and `puerta` rises, all on the same edge.
- `puerta` is high exactly DOOR_TICKS cycles, plus restarts and `paro` cycles.
- A request that appears mid-travel for a floor ahead is served when that floor is reached. This holds even if it arrives in the wrap cycle, since the latched value is checked combinationally with `boton`.
- Reset mid-travel returns to floor 0 with no pending requests; there is no homing motion.

## Structure
- `elevador_pkg`: state enum `estado_t`, the 16-entry seven-segment constant table, and a function `seg7(input [3:0])`.
- One sub-module, `seg7_dec`: registered display decoder. The scheduler, counters and latch stay in `elevador_ctrl`.

## Test plan
All scenarios use FLOORS=4, FLOOR_TICKS=4, DOOR_TICKS=3.
- Reset then idle 20 cycles:
  - `piso`=0, `display`=7'h3F, all outputs low.
- `boton`=4'b1000 for 1 cycle:
  - `motor_subir` high 12 cycles; `piso` steps 1, 2, 3.
  - At floor 3, `puerta` high 3 cycles, `pedidos`=0, then `REPOSO`.
- At floor 0, press floors 1 and 3 together:
  - Stop at floor 1 (door 3 cycles), then continue up to floor 3.
  - Never `motor_bajar`.
- At floor 2 with `dir_arriba`=1, press floor 0 only:
  - `dir_arriba` flips; `motor_bajar` high 8 cycles, then door opens at floor 0.
- Assert `paro` for 5 cycles mid-travel:
  - Motors low during `paro`; total motor-high cycles for the trip unchanged.
  - A `boton` press during `paro` still appears in `pedidos`.
- Assert `rst` mid-travel between floors 1 and 2:
  - All outputs return to reset values immediately (asynchronous); `pedidos` cleared.
